// File: rtl/ysyx_22040895_mdu_seq_if.sv
// Request/response bundle between EXU and the sequential M-extension unit.
interface ysyx_22040895_mdu_seq_if #(parameter int XLEN = 64);
    logic            in_valid_i_mdu;
    logic            in_ready_o_mdu;
    logic [2:0]      mduop_i_mdu;
    logic            word_i_mdu;
    logic [XLEN-1:0] op1_i_mdu;
    logic [XLEN-1:0] op2_i_mdu;
    logic            flush_i_mdu;
    logic            out_valid_o_mdu;
    logic            out_ready_i_mdu;
    logic [XLEN-1:0] result_o_mdu;

    modport master (
        output in_valid_i_mdu, mduop_i_mdu, word_i_mdu, op1_i_mdu, op2_i_mdu,
               flush_i_mdu, out_ready_i_mdu,
        input  in_ready_o_mdu, out_valid_o_mdu, result_o_mdu
    );
    modport slave (
        input  in_valid_i_mdu, mduop_i_mdu, word_i_mdu, op1_i_mdu, op2_i_mdu,
               flush_i_mdu, out_ready_i_mdu,
        output in_ready_o_mdu, out_valid_o_mdu, result_o_mdu
    );
endinterface

// File: rtl/ysyx_22040895_mdu_seq.sv
// Iterative RV M-extension unit: radix-2 shift-add multiplier and restoring
// divider sharing one 2*XLEN accumulator, all arithmetic done on magnitudes.
module ysyx_22040895_mdu_seq #(
    parameter int XLEN = 64,
    parameter bit W_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    ysyx_22040895_mdu_seq_if.slave mdu
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [2*XLEN-1:0]   r_acc, w_acc_nxt;
    logic [XLEN-1:0]     r_opnd, r_result;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic                r_word, r_negq, r_negr;

    function automatic logic [XLEN-1:0] f_fmt(input logic w, input logic [XLEN-1:0] v);
        return w ? XLEN'($signed(v[31:0])) : v;
    endfunction

    // Request decode: effective operands, signs, magnitudes, special divides
    logic [2:0]      w_op;
    logic            w_accept, w_word, w_sgn1, w_sgn2, w_s1, w_s2, w_dz, w_ovf;
    logic [XLEN-1:0] w_e1, w_e2, w_m1, w_m2, w_min, w_spec;

    assign w_op     = mdu.mduop_i_mdu;
    assign w_accept = mdu.in_valid_i_mdu && (r_state == S_IDLE) && !mdu.flush_i_mdu;
    // mulh* has no word form, so a word flag on it is simply ignored
    assign w_word   = mdu.word_i_mdu && W_EN && ((w_op == 3'b000) || w_op[2]);
    assign w_sgn1   = (w_op == 3'b001) || (w_op == 3'b010) || (w_op == 3'b100) || (w_op == 3'b110);
    assign w_sgn2   = (w_op == 3'b001) || (w_op == 3'b100) || (w_op == 3'b110);
    assign w_e1     = !w_word ? mdu.op1_i_mdu :
                      w_sgn1  ? XLEN'($signed(mdu.op1_i_mdu[31:0])) : XLEN'(mdu.op1_i_mdu[31:0]);
    assign w_e2     = !w_word ? mdu.op2_i_mdu :
                      w_sgn2  ? XLEN'($signed(mdu.op2_i_mdu[31:0])) : XLEN'(mdu.op2_i_mdu[31:0]);
    assign w_s1     = w_sgn1 && w_e1[XLEN-1];
    assign w_s2     = w_sgn2 && w_e2[XLEN-1];
    assign w_m1     = w_s1 ? -w_e1 : w_e1;
    assign w_m2     = w_s2 ? -w_e2 : w_e2;
    assign w_min    = w_word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_dz     = w_op[2] && (w_e2 == '0);
    assign w_ovf    = w_op[2] && w_sgn1 && (w_e1 == w_min) && (&w_e2);
    assign w_spec   = w_op[1] ? (w_dz ? w_e1 : '0) : (w_dz ? '1 : w_e1);

    // One iteration of the multiplier or divider
    logic [XLEN:0] w_sum, w_diff;
    always_comb begin
        w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_diff    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
        w_acc_nxt = r_acc;
        if (r_state == S_MUL)
            w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
        else if (r_state == S_DIV)
            w_acc_nxt = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    // Final sign fix-up and result select from the last iteration's value
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fin;
    always_comb begin
        w_prod = r_word ? (w_acc_nxt >> (XLEN-32)) : w_acc_nxt;
        if (r_negq) w_prod = -w_prod;
        w_quo  = r_negq ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
        w_rem  = r_negr ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
        if (r_op[2])
            w_fin = f_fmt(r_word, r_op[1] ? w_rem : w_quo);
        else if (r_op[1:0] == 2'b00)
            w_fin = f_fmt(r_word, w_prod[XLEN-1:0]);
        else
            w_fin = w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)
                        w_state_nxt = (w_dz || w_ovf) ? S_DONE : (w_op[2] ? S_DIV : S_MUL);
            S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (mdu.out_ready_i_mdu) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (mdu.flush_i_mdu) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_word   <= 1'b0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_word <= w_word;
            r_negq <= w_s1 ^ w_s2;
            r_negr <= w_s1;
            r_cnt  <= w_word ? CW'(31) : CW'(XLEN-1);
            if (w_op[2]) begin
                // word dividend sits at the top of the low half so 32 shifts suffice
                r_acc  <= {{XLEN{1'b0}}, (w_word ? (w_m1 << (XLEN-32)) : w_m1)};
                r_opnd <= w_m2;
            end else begin
                r_acc  <= {{XLEN{1'b0}}, w_m2};
                r_opnd <= w_m1;
            end
            if (w_dz || w_ovf) r_result <= f_fmt(w_word, w_spec);
        end else if ((r_state == S_MUL || r_state == S_DIV) && !mdu.flush_i_mdu) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_result <= w_fin;
        end
    end

    assign mdu.in_ready_o_mdu  = (r_state == S_IDLE);
    assign mdu.out_valid_o_mdu = (r_state == S_DONE);
    assign mdu.result_o_mdu    = r_result;
endmodule

// File: tb/tb_ysyx_22040895_mdu_seq.sv
// Scoreboarded random + directed bench for the sequential MDU (XLEN=64).
module tb_ysyx_22040895_mdu_seq;
    logic clk, rst;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    bit   rdy_rand = 0, rdy_force = 1;

    typedef struct { logic [63:0] res; int lat; int acc; } exp_t;
    exp_t sbq[$];

    ysyx_22040895_mdu_seq_if #(.XLEN(64)) mif();
    ysyx_22040895_mdu_seq #(.XLEN(64), .W_EN(1'b1)) dut (.clk(clk), .rst(rst), .mdu(mif));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        mif.out_ready_i_mdu = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: plain wide arithmetic straight from the ISA definitions
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb;
        logic [127:0]        p;
        logic signed [63:0]  x, y, q, rm, mn;
        logic [63:0]         ux, uy, r;
        logic                ww;
        ww = w && (op == 3'd0 || op[2]);
        r  = '0;
        case (op)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; r = ww ? sx(p[31:0]) : p[63:0]; end
            3'd1: begin pa = $signed(a); pb = $signed(b); p = pa * pb; r = p[127:64]; end
            3'd2: begin pa = $signed(a); pb = {64'b0, b}; p = pa * pb; r = p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
            3'd4, 3'd6: begin
                x  = ww ? 64'($signed(a[31:0])) : a;
                y  = ww ? 64'($signed(b[31:0])) : b;
                mn = ww ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
                if (y == 0)                 begin q = -1; rm = x; end
                else if (x == mn && y == -1) begin q = x;  rm = 0; end
                else                        begin q = x / y; rm = x % y; end
                r = (op == 3'd4) ? q : rm;
                if (ww) r = sx(r[31:0]);
            end
            default: begin
                ux = ww ? {32'b0, a[31:0]} : a;
                uy = ww ? {32'b0, b[31:0]} : b;
                if (uy == 0) r = (op == 3'd5) ? '1 : ux;
                else         r = (op == 3'd5) ? ux / uy : ux % uy;
                if (ww) r = sx(r[31:0]);
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic ww, zero, ovf;
        ww   = w && (op == 3'd0 || op[2]);
        zero = ww ? (b[31:0] == 0) : (b == 0);
        ovf  = (op == 3'd4 || op == 3'd6) &&
               (ww ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (op[2] && (zero || ovf)) return 1;
        return ww ? 33 : 65;
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return {32'b0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Drive one request; push the expectation when it is accepted
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input bit push, input bit use_exp,
                         input logic [63:0] exp);
        exp_t e;
        bit   done = 0;
        @(posedge clk); #2;
        mif.in_valid_i_mdu = 1; mif.mduop_i_mdu = op; mif.word_i_mdu = w;
        mif.op1_i_mdu = a; mif.op2_i_mdu = b;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (mif.in_ready_o_mdu) begin
                done = 1;
                e.res = use_exp ? exp : ref_res(op, w, a, b);
                e.lat = ref_lat(op, w, a, b);
                e.acc = cyc + 1;
                if (push) sbq.push_back(e);
            end
            @(posedge clk); #2;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        mif.in_valid_i_mdu = 0;
        mif.op1_i_mdu = {32'($urandom), 32'($urandom)};
        mif.op2_i_mdu = {32'($urandom), 32'($urandom)};
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || !mif.in_ready_o_mdu) && t < 500) begin
            @(negedge clk); t++;
        end
        if (t >= 500) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    // Monitor: latency on first valid, result on handshake, stability while held
    bit          seen = 0, prev_hold = 0;
    logic [63:0] prev_res;
    always @(negedge clk) begin
        if (!rst) begin
            seen = 0; prev_hold = 0;
        end else begin
            if (mif.out_valid_o_mdu && !mif.flush_i_mdu) begin
                if (sbq.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
                else begin
                    if (!seen) chk("latency", 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
                    seen = 1;
                    if (prev_hold) chk("held_result", mif.result_o_mdu, prev_res);
                    chk("in_ready_in_done", 64'(mif.in_ready_o_mdu), 64'd0);
                    if (mif.out_ready_i_mdu) begin
                        chk("result", mif.result_o_mdu, sbq[0].res);
                        void'(sbq.pop_front());
                        seen = 0;
                    end
                end
            end
            prev_hold = mif.out_valid_o_mdu && !mif.out_ready_i_mdu && !mif.flush_i_mdu;
            prev_res  = mif.result_o_mdu;
        end
    end

    initial begin
        int vcnt;
        logic [2:0] op;
        rst = 0;
        mif.in_valid_i_mdu = 0; mif.mduop_i_mdu = 0; mif.word_i_mdu = 0;
        mif.op1_i_mdu = 0; mif.op2_i_mdu = 0; mif.flush_i_mdu = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(mif.out_valid_o_mdu), 64'd0);
        chk("rst_result", mif.result_o_mdu, 64'd0);
        chk("rst_in_ready", 64'(mif.in_ready_o_mdu), 64'd1);
        @(posedge clk); #2 rst = 1;

        // Directed vectors with hand-derived results
        issue(3'd0, 0, 64'h0000_0001_0000_0003, 64'd5, 1, 1, 64'h0000_0005_0000_000F);
        issue(3'd1, 0, -64'sd2, 64'd3, 1, 1, '1);
        issue(3'd3, 0, '1, '1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(3'd4, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd6, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1, '1);
        issue(3'd5, 0, 64'h1234, 64'd0, 1, 1, '1);
        issue(3'd7, 0, 64'h1234, 64'd0, 1, 1, 64'h1234);
        issue(3'd4, 0, 64'h8000_0000_0000_0000, '1, 1, 1, 64'h8000_0000_0000_0000);
        issue(3'd6, 0, 64'h8000_0000_0000_0000, '1, 1, 1, 64'd0);
        issue(3'd2, 0, -64'sd1, '1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(3'd7, 1, 64'h0000_0000_8000_0001, 64'd0, 1, 1, 64'hFFFF_FFFF_8000_0001);
        drain();

        // Result held for 10 cycles with out_ready low
        rdy_force = 0;
        issue(3'd4, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD);
        vcnt = 0;
        while (!mif.out_valid_o_mdu && vcnt < 200) begin @(negedge clk); vcnt++; end
        chk("hold_reached_done", 64'(mif.out_valid_o_mdu), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", 64'(mif.out_valid_o_mdu), 64'd1);
            chk("hold_value", mif.result_o_mdu, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        rdy_force = 1;
        drain();

        // Flush during DIV iteration 20: no result may appear
        issue(3'd4, 0, 64'd1000, 64'd7, 0, 0, 64'd0);
        repeat (18) @(posedge clk);
        #2 mif.flush_i_mdu = 1;
        @(negedge clk);
        @(negedge clk);
        chk("flush_in_ready", 64'(mif.in_ready_o_mdu), 64'd1);
        chk("flush_out_valid", 64'(mif.out_valid_o_mdu), 64'd0);
        @(posedge clk); #2 mif.flush_i_mdu = 0;
        vcnt = 0;
        repeat (80) begin @(negedge clk); if (mif.out_valid_o_mdu) vcnt++; end
        chk("flush_no_result", 64'(vcnt), 64'd0);

        // Flush wins over a same-cycle request
        @(posedge clk); #2;
        mif.flush_i_mdu = 1; mif.in_valid_i_mdu = 1; mif.mduop_i_mdu = 3'd0;
        @(posedge clk); #2;
        mif.flush_i_mdu = 0; mif.in_valid_i_mdu = 0;
        @(negedge clk);
        chk("flush_blocks_accept", 64'(mif.in_ready_o_mdu), 64'd1);

        // Reset in the middle of a multiply
        issue(3'd3, 0, 64'd12345, 64'd678, 0, 0, 64'd0);
        repeat (10) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("midrst_out_valid", 64'(mif.out_valid_o_mdu), 64'd0);
        chk("midrst_result", mif.result_o_mdu, 64'd0);
        chk("midrst_in_ready", 64'(mif.in_ready_o_mdu), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        chk("postrst_in_ready", 64'(mif.in_ready_o_mdu), 64'd1);

        // Randomized ops with random consumer back-pressure
        rdy_rand = 1;
        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, 1'($urandom_range(0, 1)), rnd_val(), rnd_val(), 1, 0, 64'd0);
        end
        drain();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
